score_bcd_accumulator: RTL and testbench
========================================

Name: score_bcd_accumulator

Overview:
Parametrised BCD score engine that succeeds the fixed 3-digit hit counter. Each hit adds a configurable BCD point value to a DIGITS-wide packed-BCD score, using a digit-serial adder. A pending-hit queue absorbs bursts. The block also keeps a high-score register and a leading-zero blanking mask. Outputs feed per-digit hexss decoders in the top-level score display.

Parameters:
DIGITS, 4, number of BCD score digits (2..8)
HIT_POINTS, 8'h05, packed 2-digit BCD points added per hit (00..99)
PENDING_W, 4, width of pending-hit counter; max queued hits = 2^PENDING_W-1
SATURATE, 1, 1: clamp score at all-9s on overflow; 0: wrap modulo 10^DIGITS

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset, sampled on rising clk
hit  in  1  one hit per cycle asserted (level sampled each clk)
clear  in  1  synchronous score clear (new game)
commit  in  1  request high-score update (game over)
score_bcd  out  4*DIGITS  packed BCD score, digit 0 in [3:0]
high_bcd  out  4*DIGITS  packed BCD high score
lead_blank  out  DIGITS  bit i=1: digit i and all higher digits are zero; bit 0 always 0
busy  out  1  FSM not IDLE
pending_full  out  1  pending counter at max
hit_dropped  out  1  sticky: a hit arrived while pending_full
overflow  out  1  sticky: carry out of top digit occurred

Behaviour:
- Reset (resetN=0 at clk edge) has priority over everything. All outputs and state go to 0: score, high, pending, flags, FSM=IDLE, commit_req=0. Reset mid-add aborts the add with no partial result kept.
- Pending counter each cycle: +1 on hit when not full; -1 when FSM starts an add; both in the same cycle leaves it unchanged. A hit while full is discarded and sets hit_dropped. This includes a full counter in a cycle where a start also occurs, because fullness is judged on the registered value.
- FSM states: IDLE and ADD(d), with d = 0..DIGITS-1.
  - IDLE -> ADD(0) when pending != 0, decrementing pending.
  - ADD(d): score digit d <= (s_d + p_d + c) adjusted: if the sum exceeds 9, subtract 10 and set c=1, else c=0. p_d is digit d of HIT_POINTS for d<2, otherwise 0. c=0 entering ADD(0).
  - ADD(DIGITS-1) exit:
    - If c=1, set overflow. If SATURATE, score <= all 9s; otherwise keep the wrapped digits.
    - Then go to ADD(0) directly if pending != 0 (decrementing it), else go to IDLE.
- Throughput is one hit per DIGITS cycles once started. Latency from the first hit sampled into an idle empty block to the final score is DIGITS+2 edges: 1 to queue, 1 to start, then DIGITS-1 more digit updates after the first.
- score_bcd updates digit-by-digit during ADD. Intermediate values are visible; consumers treat the score as stable only when busy=0.
- commit sets commit_req. commit_req executes in the first cycle where FSM=IDLE and pending=0 (the same cycle if already idle and empty). On execution, high_bcd <= score_bcd if score_bcd > high_bcd (unsigned compare of packed BCD), and commit_req clears.
- clear: score, pending, overflow and hit_dropped go to 0 and FSM goes to IDLE. An add in progress is aborted. high_bcd is kept.
  - If commit_req executes in the same cycle, the compare uses the pre-clear score.
  - An outstanding non-executing commit_req is dropped by clear.
  - A hit coinciding with clear is discarded.
- lead_blank is combinational from score_bcd.

Test Plan:
- DIGITS=4, HIT_POINTS=05, idle: single hit pulse -> busy high 4 cycles; score_bcd=16'h0005 at edge 6 after the hit; lead_blank=4'b1110.
- 3 consecutive hit cycles -> no IDLE between adds; final score 16'h0015; pending peaks at 2; hit_dropped=0.
- PENDING_W=2, 10 consecutive hit cycles -> pending_full asserts; hit_dropped=1; final score = 5 x accepted hits as counted by the bench model.
- DIGITS=2, SATURATE=1, 20 spaced hits -> score 8'h95 after 19 hits, 8'h99 and overflow=1 after 20. With SATURATE=0: 8'h00 and overflow=1.
- Score 0015, commit -> high 0015. clear -> score 0000, high 0015. One hit, then commit -> high stays 0015. commit issued while busy -> applied only after the queue drains.
- resetN=0 during ADD(2) -> next edge: all outputs 0, FSM IDLE. Score 0105 -> lead_blank=4'b1000.

Source files
------------

// File: rtl/score_bcd_accumulator_if.sv
// rtl/score_bcd_accumulator_if.sv - hit/clear/commit inputs and score outputs of the BCD score engine
interface score_bcd_accumulator_if #(
    parameter int DIGITS = 4
);
    logic                  hit;
    logic                  clear;
    logic                  commit;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   high_bcd;
    logic [DIGITS-1:0]     lead_blank;
    logic                  busy;
    logic                  pending_full;
    logic                  hit_dropped;
    logic                  overflow;

    modport master (
        output hit, clear, commit,
        input  score_bcd, high_bcd, lead_blank, busy, pending_full, hit_dropped, overflow
    );

    modport slave (
        input  hit, clear, commit,
        output score_bcd, high_bcd, lead_blank, busy, pending_full, hit_dropped, overflow
    );
endinterface

// File: rtl/score_bcd_accumulator.sv
// rtl/score_bcd_accumulator.sv - digit-serial BCD score accumulator with hit queue and high score
module score_bcd_accumulator #(
    parameter int         DIGITS     = 4,
    parameter logic [7:0] HIT_POINTS = 8'h05,
    parameter int         PENDING_W  = 4,
    parameter bit         SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    score_bcd_accumulator_if.slave bus
);
    localparam int                   DW       = 4 * DIGITS;
    localparam int                   IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]     LAST     = IDX_W'(DIGITS - 1);
    localparam logic [PENDING_W-1:0] PEND_MAX = '1;

    typedef enum logic {IDLE, ADD} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     dig, dig_nxt;
    logic                 carry, carry_nxt;
    logic [PENDING_W-1:0] pending, pending_nxt;
    logic [DW-1:0]        score, score_nxt;
    logic [DW-1:0]        high, high_nxt;
    logic                 commit_req, commit_req_nxt;
    logic                 dropped, dropped_nxt;
    logic                 ovf, ovf_nxt;

    logic                 full;
    logic                 accept;
    logic                 start;
    logic                 commit_exec;
    logic [3:0]           s_d;
    logic [3:0]           p_d;
    logic [4:0]           sum;
    logic [3:0]           sum_digit;
    logic                 sum_carry;
    logic [DIGITS-1:0]    blank;
    logic                 zero_above;

    // One BCD digit add for the digit currently being processed
    always_comb begin
        s_d = score[{dig, 2'b00} +: 4];
        p_d = 4'h0;
        if (dig == '0)
            p_d = HIT_POINTS[3:0];
        else if (dig == IDX_W'(1))
            p_d = HIT_POINTS[7:4];
        sum = {1'b0, s_d} + {1'b0, p_d} + {4'b0000, carry};
        if (sum > 5'd9) begin
            sum_digit = 4'(sum - 5'd10);
            sum_carry = 1'b1;
        end else begin
            sum_digit = sum[3:0];
            sum_carry = 1'b0;
        end
    end

    // Next-state: queue bookkeeping, digit-serial FSM, commit and clear handling
    always_comb begin
        state_nxt      = state;
        dig_nxt        = dig;
        carry_nxt      = carry;
        pending_nxt    = pending;
        score_nxt      = score;
        high_nxt       = high;
        commit_req_nxt = commit_req | bus.commit;
        dropped_nxt    = dropped;
        ovf_nxt        = ovf;
        start          = 1'b0;
        full           = (pending == PEND_MAX);
        accept         = bus.hit && !full;
        commit_exec    = (commit_req || bus.commit) && (state == IDLE) && (pending == '0);

        // Commit compares against the score as it stands this cycle, i.e. before any clear
        if (commit_exec) begin
            if (score > high)
                high_nxt = score;
            commit_req_nxt = 1'b0;
        end

        if (bus.clear) begin
            state_nxt      = IDLE;
            dig_nxt        = '0;
            carry_nxt      = 1'b0;
            pending_nxt    = '0;
            score_nxt      = '0;
            dropped_nxt    = 1'b0;
            ovf_nxt        = 1'b0;
            commit_req_nxt = 1'b0;
        end else begin
            if (bus.hit && full)
                dropped_nxt = 1'b1;
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        start     = 1'b1;
                        state_nxt = ADD;
                        dig_nxt   = '0;
                        carry_nxt = 1'b0;
                    end
                end
                ADD: begin
                    score_nxt[{dig, 2'b00} +: 4] = sum_digit;
                    carry_nxt = sum_carry;
                    dig_nxt   = dig + 1'b1;
                    if (dig == LAST) begin
                        if (sum_carry) begin
                            ovf_nxt = 1'b1;
                            if (SATURATE)
                                score_nxt = {DIGITS{4'h9}};
                        end
                        carry_nxt = 1'b0;
                        dig_nxt   = '0;
                        if (pending != '0)
                            start = 1'b1;
                        else
                            state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            pending_nxt = pending + PENDING_W'(accept) - PENDING_W'(start);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            dig        <= '0;
            carry      <= 1'b0;
            pending    <= '0;
            score      <= '0;
            high       <= '0;
            commit_req <= 1'b0;
            dropped    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            dig        <= dig_nxt;
            carry      <= carry_nxt;
            pending    <= pending_nxt;
            score      <= score_nxt;
            high       <= high_nxt;
            commit_req <= commit_req_nxt;
            dropped    <= dropped_nxt;
            ovf        <= ovf_nxt;
        end
    end

    // Leading-zero blanking: digit i blanks when it and every digit above it are zero
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (score[4*i +: 4] == 4'h0);
            blank[i]   = zero_above;
        end
    end

    assign bus.score_bcd    = score;
    assign bus.high_bcd     = high;
    assign bus.lead_blank   = blank;
    assign bus.busy         = (state == ADD);
    assign bus.pending_full = full;
    assign bus.hit_dropped  = dropped;
    assign bus.overflow     = ovf;
endmodule

// File: tb/tb_score_bcd_accumulator.sv
// tb/tb_score_bcd_accumulator.sv - scoreboard bench for score_bcd_accumulator
module tb_score_bcd_accumulator;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    score_bcd_accumulator_if #(.DIGITS(4)) a_if ();
    score_bcd_accumulator_if #(.DIGITS(4)) p_if ();
    score_bcd_accumulator_if #(.DIGITS(2)) s_if ();
    score_bcd_accumulator_if #(.DIGITS(2)) w_if ();

    score_bcd_accumulator #(.DIGITS(4), .HIT_POINTS(8'h05), .PENDING_W(4), .SATURATE(1'b1))
        u_main (.clk(clk), .resetN(resetN), .bus(a_if.slave));
    score_bcd_accumulator #(.DIGITS(4), .HIT_POINTS(8'h05), .PENDING_W(2), .SATURATE(1'b1))
        u_pw2  (.clk(clk), .resetN(resetN), .bus(p_if.slave));
    score_bcd_accumulator #(.DIGITS(2), .HIT_POINTS(8'h05), .PENDING_W(4), .SATURATE(1'b1))
        u_sat  (.clk(clk), .resetN(resetN), .bus(s_if.slave));
    score_bcd_accumulator #(.DIGITS(2), .HIT_POINTS(8'h05), .PENDING_W(4), .SATURATE(1'b0))
        u_wrap (.clk(clk), .resetN(resetN), .bus(w_if.slave));

    int compared = 0;
    int mismatched = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] obs_score(input int id);
        case (id)
            0:       return 32'(a_if.score_bcd);
            1:       return 32'(p_if.score_bcd);
            2:       return 32'(s_if.score_bcd);
            default: return 32'(w_if.score_bcd);
        endcase
    endfunction

    // Waits (bounded) until every engine is idle, then pops one expected score per id given
    task automatic drain(input string tag, input int id);
        int n;
        logic [31:0] exp;
        n = 0;
        repeat (2) @(negedge clk);
        while ((a_if.busy | p_if.busy | s_if.busy | w_if.busy) === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(n < 400), 32'd1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check(tag, obs_score(id), exp);
    endtask

    task automatic pulse_hits_main(input int count);
        for (int i = 0; i < count; i++) begin
            a_if.hit = 1'b1;
            @(negedge clk);
        end
        a_if.hit = 1'b0;
    endtask

    int m_main;
    int m_sat;
    int m_wrap;
    int mp, md, acc;
    bit madd, mfull, mstart, pfull_seen;

    initial begin
        a_if.hit = 0; a_if.clear = 0; a_if.commit = 0;
        p_if.hit = 0; p_if.clear = 0; p_if.commit = 0;
        s_if.hit = 0; s_if.clear = 0; s_if.commit = 0;
        w_if.hit = 0; w_if.clear = 0; w_if.commit = 0;
        resetN = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_score", 32'(a_if.score_bcd), 32'h0);
        check("rst_high", 32'(a_if.high_bcd), 32'h0);
        check("rst_busy", 32'(a_if.busy), 32'h0);
        check("rst_flags", {29'h0, a_if.pending_full, a_if.hit_dropped, a_if.overflow}, 32'h0);
        check("rst_lead_blank", 32'(a_if.lead_blank), 32'hE);
        resetN = 1'b1;
        @(negedge clk);

        // single hit: busy exactly on edges 2..5 after the hit
        m_main = 5;
        sb_q.push_back(to_bcd(m_main));
        a_if.hit = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            a_if.hit = 1'b0;
            check($sformatf("t1_busy_e%0d", e), 32'(a_if.busy), 32'(e >= 2 && e <= 5));
        end
        check("t1_score_e6", obs_score(0), sb_q.pop_front());
        check("t1_lead_blank", 32'(a_if.lead_blank), 32'hE);

        // clear then three back-to-back hits
        a_if.clear = 1'b1;
        @(negedge clk);
        a_if.clear = 1'b0;
        check("t2_clear_score", 32'(a_if.score_bcd), 32'h0);
        m_main = 15;
        sb_q.push_back(to_bcd(m_main));
        pulse_hits_main(3);
        drain("t2_score", 0);
        check("t2_dropped", 32'(a_if.hit_dropped), 32'h0);

        // commit on idle block, then clear keeps high score
        a_if.commit = 1'b1;
        @(negedge clk);
        a_if.commit = 1'b0;
        check("t3_high", 32'(a_if.high_bcd), 32'h0015);
        a_if.clear = 1'b1;
        @(negedge clk);
        a_if.clear = 1'b0;
        check("t3_clear_score", 32'(a_if.score_bcd), 32'h0);
        check("t3_clear_high", 32'(a_if.high_bcd), 32'h0015);
        m_main = 5;
        sb_q.push_back(to_bcd(m_main));
        pulse_hits_main(1);
        drain("t3_score", 0);
        a_if.commit = 1'b1;
        @(negedge clk);
        a_if.commit = 1'b0;
        @(negedge clk);
        check("t3_high_kept", 32'(a_if.high_bcd), 32'h0015);

        // commit while busy is deferred until the queue drains
        m_main = m_main + 4 * 5;
        sb_q.push_back(to_bcd(m_main));
        pulse_hits_main(4);
        a_if.commit = 1'b1;
        check("t4_busy_at_commit", 32'(a_if.busy), 32'h1);
        @(negedge clk);
        a_if.commit = 1'b0;
        check("t4_high_deferred", 32'(a_if.high_bcd), 32'h0015);
        drain("t4_score", 0);
        @(negedge clk);
        check("t4_high_applied", 32'(a_if.high_bcd), 32'h0025);

        // long burst up to 0105, lead blanking of the top digit only
        m_main = m_main + 16 * 5;
        sb_q.push_back(to_bcd(m_main));
        pulse_hits_main(16);
        drain("t5_score", 0);
        check("t5_lead_blank", 32'(a_if.lead_blank), 32'h8);
        check("t5_dropped", 32'(a_if.hit_dropped), 32'h0);

        // PENDING_W=2: ten consecutive hits, queue model decides which are accepted
        mp = 0; md = 0; acc = 0; madd = 0; pfull_seen = 0;
        p_if.hit = 1'b1;
        for (int e = 0; e < 10; e++) begin
            mfull  = (mp == 3);
            mstart = (mp != 0) && (!madd || md == 3);
            if (!mfull) acc++;
            mp = mp + (mfull ? 0 : 1) - (mstart ? 1 : 0);
            if (madd) begin
                if (md == 3) begin md = 0; madd = mstart; end
                else md++;
            end else if (mstart) begin
                madd = 1; md = 0;
            end
            @(negedge clk);
            pfull_seen |= p_if.pending_full;
        end
        p_if.hit = 1'b0;
        sb_q.push_back(to_bcd(5 * acc));
        drain("t6_score", 1);
        check("t6_full_seen", 32'(pfull_seen), 32'h1);
        check("t6_dropped", 32'(p_if.hit_dropped), 32'h1);

        // DIGITS=2 saturate vs wrap over 20 spaced hits
        m_sat = 0; m_wrap = 0;
        for (int i = 1; i <= 20; i++) begin
            s_if.hit = 1'b1;
            w_if.hit = 1'b1;
            m_sat  = (m_sat + 5 > 99) ? 99 : m_sat + 5;
            m_wrap = (m_wrap + 5) % 100;
            @(negedge clk);
            s_if.hit = 1'b0;
            w_if.hit = 1'b0;
            if (i >= 19) begin
                sb_q.push_back(to_bcd(m_sat));
                drain($sformatf("t7_sat_%0d", i), 2);
                sb_q.push_back(to_bcd(m_wrap));
                drain($sformatf("t7_wrap_%0d", i), 3);
                check($sformatf("t7_sat_ovf_%0d", i), 32'(s_if.overflow), 32'(i == 20));
                check($sformatf("t7_wrap_ovf_%0d", i), 32'(w_if.overflow), 32'(i == 20));
            end else begin
                repeat (6) @(negedge clk);
            end
        end

        // reset while the main engine sits in ADD(2)
        a_if.hit = 1'b1;
        repeat (4) begin
            @(negedge clk);
            a_if.hit = 1'b0;
        end
        check("t8_busy_before_rst", 32'(a_if.busy), 32'h1);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        check("t8_score", 32'(a_if.score_bcd), 32'h0);
        check("t8_high", 32'(a_if.high_bcd), 32'h0);
        check("t8_busy", 32'(a_if.busy), 32'h0);
        check("t8_flags", {29'h0, a_if.pending_full, a_if.hit_dropped, a_if.overflow}, 32'h0);
        check("t8_sat_ovf", 32'(s_if.overflow), 32'h0);
        repeat (6) @(negedge clk);
        check("t8_no_resume", 32'(a_if.score_bcd), 32'h0);
        check("t8_idle_after", 32'(a_if.busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
